// File: rtl/dp_pipe.sv
// dp_pipe: two-stage (register read / execute) pipelined datapath with writeback.
// Define DP_PIPE_BYPASS_EN to forward the ALU result on a hazard instead of stalling.
module dp_pipe #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    parameter int IMM_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] rs,
    input  logic [$clog2(NREGS)-1:0] rt,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [3:0]               op,
    input  logic [IMM_W-1:0]         imm,
    input  logic                     sel,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         result,
    output logic                     zero,
    output logic                     carry,
    output logic                     overflow
);
    localparam int AW = $clog2(NREGS);
    localparam int EW = IMM_W > WIDTH ? IMM_W : WIDTH;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100;

    function automatic logic legal(input logic [3:0] o);
        return o inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
    endfunction

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [3:0]       op_q, op_d;
    logic             v_q, v_d, ov_q, ov_d, z_q, z_d, c_q, c_d, o_q, o_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] addend, alu_r, ra, rb, imm_x;
    logic [EW-1:0]    imm_s, imm_z;
    logic             alu_c, alu_o, rd_hit, hit_a, hit_b;

    always_comb begin
        addend = op_q == OP_SUB ? ~b_q : b_q;
        sum    = {1'b0, a_q} + {1'b0, addend} + {{WIDTH{1'b0}}, op_q == OP_SUB};
        alu_r  = '0;
        alu_c  = 1'b0;
        alu_o  = 1'b0;
        case (op_q)
            OP_AND: alu_r = a_q & b_q;
            OP_OR:  alu_r = a_q | b_q;
            OP_NOR: alu_r = ~(a_q | b_q);
            OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_ADD, OP_SUB: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_o = (a_q[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            default: ;
        endcase
    end

    // The RD-stage instruction writes back on the edge that moves it to EX
    assign rd_hit = v_q && legal(op_q) && rd_q != '0;
    assign hit_a  = rd_hit && rs == rd_q;
    assign hit_b  = rd_hit && !sel && rt == rd_q;

    always_comb begin
        imm_s = EW'($signed(imm));
        imm_z = EW'(imm);
        imm_x = op inside {OP_ADD, OP_SUB, OP_SLT} ? imm_s[WIDTH-1:0] : imm_z[WIDTH-1:0];
`ifdef DP_PIPE_BYPASS_EN
        in_ready = 1'b1;
        ra = hit_a ? alu_r : (rs == '0 ? '0 : regs_q[rs]);
        rb = hit_b ? alu_r : (rt == '0 ? '0 : regs_q[rt]);
`else
        in_ready = !(in_valid && (hit_a || hit_b));
        ra = rs == '0 ? '0 : regs_q[rs];
        rb = rt == '0 ? '0 : regs_q[rt];
`endif
        a_d  = ra;
        b_d  = sel ? imm_x : rb;
        rd_d = rd;
        op_d = op;
        v_d  = in_valid && in_ready;
        ov_d = v_q;
        res_d = v_q ? alu_r : res_q;
        z_d   = v_q ? legal(op_q) && alu_r == '0 : z_q;
        c_d   = v_q ? alu_c : c_q;
        o_d   = v_q ? alu_o : o_q;
        regs_d = regs_q;
        if (rd_hit) regs_d[rd_q] = alu_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= WIDTH'(i);
            a_q   <= '0;
            b_q   <= '0;
            rd_q  <= '0;
            op_q  <= '0;
            v_q   <= 1'b0;
            ov_q  <= 1'b0;
            res_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            o_q   <= 1'b0;
        end else begin
            regs_q <= regs_d;
            a_q    <= a_d;
            b_q    <= b_d;
            rd_q   <= rd_d;
            op_q   <= op_d;
            v_q    <= v_d;
            ov_q   <= ov_d;
            res_q  <= res_d;
            z_q    <= z_d;
            c_q    <= c_d;
            o_q    <= o_d;
        end
    end

    assign out_valid = ov_q;
    assign result    = res_q;
    assign zero      = z_q;
    assign carry     = c_q;
    assign overflow  = o_q;
endmodule

// File: tb/tb_dp_pipe.sv
// tb_dp_pipe: scoreboard bench for dp_pipe (32-bit instance plus an 8-bit instance for overflow).
module tb_dp_pipe;
    typedef struct {
        logic [31:0] r;
        logic        z, c, o;
        int          cyc;
        string       nm;
    } exp_t;

    logic clk = 0, rst_n = 0;
    int   cyc = 0, tests = 0, fails = 0;
    exp_t q32[$], q8[$];

    logic        in_valid = 0, sel = 0, in_ready, out_valid, zero, carry, overflow;
    logic [4:0]  rs = 0, rt = 0, rd = 0;
    logic [3:0]  op = 0;
    logic [15:0] imm = 0;
    logic [31:0] result;

    logic        v8 = 0, sel8 = 0, rdy8, ov8, z8, c8, o8;
    logic [2:0]  rs8 = 0, rt8 = 0, rd8 = 0;
    logic [3:0]  op8 = 0;
    logic [15:0] imm8 = 0;
    logic [7:0]  res8;

    dp_pipe dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .rt(rt), .rd(rd), .op(op), .imm(imm), .sel(sel), .out_valid(out_valid),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow));

    dp_pipe #(.WIDTH(8), .NREGS(8), .IMM_W(16)) dut8 (.clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(rdy8), .rs(rs8), .rt(rt8), .rd(rd8), .op(op8), .imm(imm8),
        .sel(sel8), .out_valid(ov8), .result(res8), .zero(z8), .carry(c8), .overflow(o8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic pop_chk(inout exp_t q[$], input logic [31:0] r, input logic z, c, o);
        exp_t e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %h with empty queue", r);
        end else begin
            e = q.pop_front();
            chk({e.nm, "_val"}, {28'd0, r, z, c, o}, {28'd0, e.r, e.z, e.c, e.o});
            chk({e.nm, "_lat"}, 64'(cyc), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) if (rst_n && out_valid) pop_chk(q32, result, zero, carry, overflow);
    always @(negedge clk) if (rst_n && ov8) pop_chk(q8, {24'd0, res8}, z8, c8, o8);

    task automatic issue(input logic [4:0] s, t, d, input logic [3:0] o, input logic [15:0] im,
                         input logic sl, input logic push, input logic [31:0] er,
                         input logic ez, ec, eo, input string nm, output int stalls);
        stalls = 0;
        @(negedge clk);
        {rs, rt, rd, op, imm, sel, in_valid} = {s, t, d, o, im, sl, 1'b1};
        #1;
        while (!in_ready && stalls < 4) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_stall: in_ready stuck low", nm);
        end else if (push) q32.push_back('{er, ez, ec, eo, cyc + 2, nm});
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic issue8(input logic [2:0] s, t, d, input logic [3:0] o, input logic [15:0] im,
                          input logic sl, input logic [7:0] er, input logic ez, ec, eo,
                          input string nm);
        int stalls = 0;
        @(negedge clk);
        {rs8, rt8, rd8, op8, imm8, sel8, v8} = {s, t, d, o, im, sl, 1'b1};
        #1;
        while (!rdy8 && stalls < 4) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (!rdy8) begin
            tests++;
            fails++;
            $display("FAIL %s_stall: in_ready stuck low", nm);
        end else q8.push_back('{{24'd0, er}, ez, ec, eo, cyc + 2, nm});
        @(posedge clk);
        #1 v8 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, exp_st;
`ifdef DP_PIPE_BYPASS_EN
        exp_st = 0;
`else
        exp_st = 1;
`endif
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'({zero, carry, overflow}), 64'd0);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, out_valid, result}, 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        issue(1, 2, 0, 4'b0000, 0, 0, 1, 32'h0, 1, 0, 0, "and", st);
        issue(1, 2, 0, 4'b0001, 0, 0, 1, 32'h3, 0, 0, 0, "or", st);
        issue(1, 2, 0, 4'b0110, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, "sub", st);
        issue(1, 2, 0, 4'b0111, 0, 0, 1, 32'h1, 0, 0, 0, "slt", st);
        issue(1, 2, 0, 4'b1100, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, "nor", st);
        issue(1, 0, 0, 4'b0010, 16'hFFFF, 1, 1, 32'h0, 1, 1, 0, "addi", st);

        issue(1, 2, 3, 4'b0001, 0, 0, 1, 32'h3, 0, 0, 0, "haz_or", st);
        issue(3, 3, 4, 4'b0010, 0, 0, 1, 32'h6, 0, 0, 0, "haz_add", st);
        chk("haz_stalls", 64'(st), 64'(exp_st));
        issue(4, 0, 0, 4'b0001, 0, 0, 1, 32'h6, 0, 0, 0, "rd_r4", st);

        issue(1, 0, 0, 4'b0010, 16'h0005, 1, 1, 32'h6, 0, 0, 0, "wr_r0", st);
        issue(0, 0, 0, 4'b0001, 0, 0, 1, 32'h0, 1, 0, 0, "rd_r0", st);
        chk("r0_no_stall", 64'(st), 64'd0);

        issue(1, 2, 6, 4'b0101, 0, 0, 1, 32'h0, 0, 0, 0, "illegal", st);
        issue(6, 0, 0, 4'b0001, 0, 0, 1, 32'h6, 0, 0, 0, "rd_r6", st);

        issue8(0, 0, 5, 4'b0001, 16'h007F, 1, 8'h7F, 0, 0, 0, "w8_or");
        issue8(5, 1, 0, 4'b0010, 0, 0, 8'h80, 0, 0, 1, "w8_ovf");

        issue(1, 2, 0, 4'b0000, 0, 0, 1, 32'h0, 1, 0, 0, "pre_rst", st);
        issue(1, 1, 3, 4'b0010, 0, 0, 0, 32'h0, 0, 0, 0, "lost", st);
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk("rst_drops_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1;
        issue(3, 0, 0, 4'b0001, 0, 0, 1, 32'h3, 0, 0, 0, "rd_r3", st);
        issue(4, 0, 0, 4'b0001, 0, 0, 1, 32'h4, 0, 0, 0, "rd_r4_reinit", st);

        repeat (4) @(negedge clk);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dp_pipe.md
# dp_pipe

Parametrised two-stage pipelined MIPS-style datapath: a register file feeding an ALU, with register or immediate second operand and result writeback. It is the next-generation replacement for the single-cycle `dp` datapath, generalised in data width and register count. It adds registered issue/result handshakes, writeback hazard handling and reset-defined register contents. It sits between the instruction decode stage and the future memory stage.

## Interface
- `WIDTH`, 32: datapath width in bits; minimum 4.
- `NREGS`, 32: number of registers; power of two, minimum 4. `AW = $clog2(NREGS)`.
- `IMM_W`, 16: immediate field width.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: an instruction is presented.
- `in_ready` out 1: the instruction is accepted on an edge where `in_valid & in_ready` is high.
- `rs`, `rt`, `rd` in AW: source A, source B and destination register indices.
- `op` in 4: ALU operation code.
- `imm` in IMM_W: immediate operand.
- `sel` in 1: 0 selects `rt` as operand B; 1 selects the extended `imm`.
- `out_valid` out 1: the result and flags are valid for one cycle.
- `result` out WIDTH: ALU result.
- `zero`, `carry`, `overflow` out 1: ALU flags.

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR.
- Any other opcode: `result` = 0, all flags 0, `out_valid` still pulses, no writeback.
- Immediate extension:
  - ADD/SUB/SLT: sign-extend `imm`.
  - AND/OR/NOR: zero-extend `imm`.
  - In both cases extend to max(IMM_W, WIDTH), then truncate to WIDTH.
- Arithmetic is computed in WIDTH+1 bits.
  - ADD: `carry` = carry-out.
  - SUB: A + ~B + 1; `carry` = carry-out, so 1 means no borrow.
  - `overflow` = signed overflow for ADD and SUB only; 0 for all other ops.
  - `carry` = 0 for logic ops and SLT.
  - `zero` = (`result` == 0) for every legal op.
- Register 0 always reads 0; writes to it are discarded.
- Register k resets to value k, truncated to WIDTH.
- Pipeline:
  - Stage 1 (RD) captures operand A, operand B, `rd`, `op`, `sel` and a valid bit.
  - Stage 2 (EX) captures the result, flags and valid bit, and writes `result` to `rd` on the same edge.
- Hazard: the instruction in RD has a legal op and `rd` ≠ 0, and the incoming instruction reads that register through `rs`, or through `rt` with `sel` = 0.
- `in_ready` is 1 whenever no hazard exists (see Configuration).
- Reset mid-operation clears both valid bits immediately. In-flight instructions are lost and the registers reinitialise.

## Timing
- Instruction accepted at edge E0: operands latched at E0; `result`, flags and `out_valid` registered at E1, and visible in the cycle after E1.
- Latency is 2 edges from issue to visible result.
- Throughput is one instruction per cycle when there is no hazard stall.
- Writeback occurs at E1, so a read issued after E1 sees the new value directly.
- Reset values: `out_valid` 0, `result` 0, `zero` 0, `carry` 0, `overflow` 0, pipeline valids 0.
- `in_ready` is combinational from the inputs and RD-stage state.

## Configuration
- `DP_PIPE_BYPASS_EN` defined:
  - The EX-stage ALU output is forwarded into the RD-stage operand capture on a hazard.
  - `in_ready` is tied to 1.
- `DP_PIPE_BYPASS_EN` undefined:
  - On a hazard, `in_ready` = 0 for exactly one cycle and RD inserts a bubble (valid 0).
  - The instruction must be held stable and is accepted on the next edge.

## Test plan
- Reset, then issue `rs`=1, `rt`=2, `sel`=0 for AND/OR/SUB/SLT/NOR, one per cycle -> results 0x0, 0x3, 0xFFFFFFFF (`carry`=0), 0x1, 0xFFFFFFFC, each 2 edges after issue.
- ADD `rs`=1 with `imm`=0xFFFF, `sel`=1 -> `result`=0, `zero`=1, `carry`=1, `overflow`=0.
- Overflow check with WIDTH=8, NREGS=8:
  - OR `rs`=0, `imm`=0x7F, `rd`=5.
  - Then ADD `rs`=5, `rt`=1 -> `result`=0x80, `overflow`=1, `carry`=0.
- Back-to-back hazard: OR `rs`=1, `rt`=2, `rd`=3, then immediately ADD `rs`=3, `rt`=3, `rd`=4 -> second result 6.
  - With `DP_PIPE_BYPASS_EN`: `in_ready` stays 1.
  - Without it: `in_ready` is low one cycle and the result arrives one cycle later.
- Write to `rd`=0, then read register 0 -> reads 0.
- Illegal op 0101 -> `out_valid`=1, `result`=0, `rd` unchanged.
- Assert `rst_n`=0 while `out_valid` is pending -> `out_valid` drops immediately, no writeback occurs, and register 3 reads 3 after release.
